// File: rtl/core_pkg.sv
// Shared opcode constants, sequencer states and instruction classes
// for the first-core multi-cycle sequencer.
package core_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP1    = 6'b010001;
  localparam logic [5:0] OP_COP2    = 6'b010010;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_LWC1    = 6'b110001;
  localparam logic [5:0] OP_LWC2    = 6'b110010;
  localparam logic [5:0] OP_SWC1    = 6'b111001;
  localparam logic [5:0] OP_SWC2    = 6'b111010;
  localparam logic [5:0] OP_OUT     = 6'b111111;

  localparam logic [5:0] FUNC_JR    = 6'b001000;

  localparam logic [4:0] FLOAT_MF   = 5'b00000;
  localparam logic [4:0] FLOAT_BC   = 5'b01000;
  localparam logic [4:0] FLOAT_S    = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_HALT,
    S_ERR
  } seq_state_t;

  typedef enum logic [2:0] {
    WR,
    ST,
    BR,
    LINK,
    RX,
    TX,
    HALT,
    BAD
  } op_class_t;

  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_OP   = 2'd1;
  localparam err_code_t ERR_TMO  = 2'd2;

  // Completion-event bit positions
  localparam int EV_WR = 0;
  localparam int EV_ST = 1;
  localparam int EV_JP = 2;
  localparam int EV_RX = 3;
  localparam int EV_TX = 4;

  typedef logic [4:0] ev_mask_t;

  // Events an instruction class must see before it retires;
  // the PC update is part of every class.
  function automatic ev_mask_t need_mask(op_class_t c);
    ev_mask_t m;
    m = '0;
    m[EV_JP] = 1'b1;
    unique case (c)
      WR, LINK: m[EV_WR] = 1'b1;
      ST:       m[EV_ST] = 1'b1;
      RX:       m[EV_RX] = 1'b1;
      TX:       m[EV_TX] = 1'b1;
      default:  ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/op_classify.sv
// Full opcode/function decode of an instruction word
// into its sequencing class.
module op_classify
  import core_pkg::*;
(
  input  logic [31:0] op,
  output op_class_t   cls
);

  logic [5:0] opc;
  logic [5:0] fn;
  logic [4:0] rs;
  logic       unused_bits;

  assign opc = op[31:26];
  assign fn  = op[5:0];
  assign rs  = op[25:21];
  assign unused_bits = ^op[20:6];

  // Opcode -> class; anything not listed is an illegal instruction
  always_comb begin
    cls = BAD;
    unique case (opc)
      OP_SPECIAL: cls = (fn == FUNC_JR) ? BR : WR;
      OP_ADDI,
      OP_SLTI,
      OP_LUI,
      OP_LW,
      OP_LWC1:    cls = WR;
      OP_COP1: begin
        unique case (rs)
          FLOAT_MF: cls = WR;
          FLOAT_S:  cls = WR;
          FLOAT_BC: cls = BR;
          default:  cls = BAD;
        endcase
      end
      OP_COP2:    cls = (rs == FLOAT_MF) ? WR : BAD;
      OP_SW,
      OP_SWC1:    cls = ST;
      OP_J,
      OP_BEQ,
      OP_BNE:     cls = BR;
      OP_JAL:     cls = LINK;
      OP_LWC2:    cls = RX;
      OP_SWC2:    cls = TX;
      OP_OUT:     cls = HALT;
      default:    cls = BAD;
    endcase
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: fetch, issue with a d_valid
// pulse, wait for all completion events, with halt and watchdog.
module core_seq
  import core_pkg::*;
#(
  parameter int IMEM_LAT = 2,
  parameter int TIMEOUT  = 1023,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      inst,
  output logic [31:0]      op,
  output logic             d_valid,
  input  logic             write_finish,
  input  logic             store_finish,
  input  logic             jump_finish,
  input  logic             uart_recv_valid,
  input  logic             uart_send_done,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0]      FETCH_LAST = 3'(IMEM_LAT - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  seq_state_t      state;
  logic [2:0]      fcnt;
  logic [WD_W-1:0] wcnt;
  ev_mask_t        need;
  ev_mask_t        flags;
  ev_mask_t        ev;
  ev_mask_t        seen;
  op_class_t       cls_in;
  op_class_t       cls_q;
  logic            done;
  logic            issue;

  op_classify u_cls (
    .op  (inst),
    .cls (cls_in)
  );

  assign ev = {
    uart_send_done,
    uart_recv_valid,
    jump_finish,
    store_finish,
    write_finish
  };

  // Flags already held plus this cycle's events count toward completion
  assign seen  = flags | ev;
  assign done  = ((need & ~seen) == '0);
  assign issue = (cls_in != HALT) && (cls_in != BAD);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      fcnt     <= '0;
      wcnt     <= '0;
      need     <= '0;
      flags    <= '0;
      cls_q    <= BAD;
      op       <= '0;
      d_valid  <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      retired  <= '0;
    end else begin
      d_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            fcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fcnt == FETCH_LAST) begin
            op      <= inst;
            cls_q   <= cls_in;
            d_valid <= issue;
            state   <= S_DECODE;
          end else begin
            fcnt <= fcnt + 3'd1;
          end
        end
        S_DECODE: begin
          need  <= need_mask(cls_q);
          flags <= '0;
          wcnt  <= '0;
          if (cls_q == HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (cls_q == BAD) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_OP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
            fcnt    <= '0;
          end else if (wcnt == WD_LAST) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TMO;
          end else begin
            flags <= seen;
            wcnt  <= wcnt + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
